reqack_tph2rdyval_fifo: RTL

- Buffered converter from a two-phase (toggle) request/acknowledge input to a ready/valid output stream.
- Next generation of the single-slot two-phase to ready/valid bridge: DEPTH-entry FIFO between the interfaces, occupancy output, fully parametrised width and depth.
- The sender keeps issuing words while the downstream consumer stalls; ack is withheld only when the FIFO is full.
- Optional 2-flop CDC on req for a sender in another clock domain.

---
 rtl/reqack_tph2rdyval_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/reqack_tph2rdyval_fifo.sv
// Two-phase req/ack to ready/valid converter with a DEPTH-entry FIFO and occupancy output.
// Define REQACK_TPH2RDYVAL_FIFO_CHECKS_EN to compile embedded protocol assertions.
module reqack_tph2rdyval_fifo #(
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 4,
  parameter bit INCLUDE_CDC = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  output logic                       ack,
  input  logic [DWIDTH-1:0]          i_dat,
  input  logic                       rdy,
  output logic                       vld,
  output logic [DWIDTH-1:0]          o_dat,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              ack_q, ack_d, vld_q, vld_d;
  logic [DWIDTH-1:0] o_dat_q, o_dat_d;
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic              req_s, pending, push, pop;

  always_comb begin
    sync1_d  = req;
    sync2_d  = sync1_q;
    req_s    = INCLUDE_CDC ? sync2_q : req;
    pending  = (req_s != ack_q);
    push     = pending && (level_q != LW'(DEPTH));
    pop      = vld_q && rdy;
    ack_d    = push ? ~ack_q : ack_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_dat;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
    vld_d = (level_d != '0);
    // Head register looks through this cycle's write so a word pushed into an
    // empty (or just-drained) FIFO is presented at the very next edge.
    o_dat_d = o_dat_q;
    if (level_d != '0)
      o_dat_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      ack_q    <= 1'b0;
      vld_q    <= 1'b0;
      o_dat_q  <= '0;
      level_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      ack_q    <= ack_d;
      vld_q    <= vld_d;
      o_dat_q  <= o_dat_d;
      level_q  <= level_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset; only entries below level are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ack   = ack_q;
  assign vld   = vld_q;
  assign o_dat = o_dat_q;
  assign level = level_q;

`ifdef REQACK_TPH2RDYVAL_FIFO_CHECKS_EN
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (vld_q && !rdy) |=> (vld_q && $stable(o_dat_q)))
    else $error("output changed while stalled");
  a_ack_only_on_push: assert property (@(posedge clk) disable iff (rst)
    ($changed(ack_q) && !$past(rst)) |-> $past(push))
    else $error("ack toggled without an accepted word");
  a_level_range: assert property (@(posedge clk) disable iff (rst)
    level_q <= LW'(DEPTH))
    else $error("level exceeds DEPTH");
  a_empty_iff_invalid: assert property (@(posedge clk) disable iff (rst)
    (level_q == '0) == !vld_q)
    else $error("vld inconsistent with level");
  if (!INCLUDE_CDC) begin : g_dat_stable
    a_dat_stable: assert property (@(posedge clk) disable iff (rst)
      (pending && !$past(rst) && $past(pending && !push)) |-> $stable(i_dat))
      else $error("i_dat changed while request pending");
  end
`endif
endmodule
